mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/lat_counter.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the mem_port_arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   - grant_e     : identity of the most recent grant (used by the optional
//                   fairness flag enabled with the ARB_FAIR_EN macro)
//   - MEM_LAT_DEFAULT, AW_DEFAULT : default parameter values
//   - CNT_W       : latency counter width (covers MEM_LAT up to 15)
package mem_port_arbiter_pkg;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int AW_DEFAULT      = 32;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/lat_counter.sv
// Down-counter that times one memory access.
// Ports:
//   clk, reset (async, active-high)
//   load     : load load_val (takes precedence over dec)
//   load_val : value loaded at grant (MEM_LAT-1)
//   dec      : decrement by one; ignored when already zero
//   zero     : count is zero (final latency cycle while an access is live)
module lat_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops are written with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (IF) and the
// data (MEM) stage of a pipeline.
// Parameters: MEM_LAT (1..15) access latency in cycles, AW address/data width.
// Ports:
//   clk, reset (async, active-high)
//   if_req/if_addr -> if_rdata/if_ready       : fetch read port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready : data port
//   stall                                     : pipeline freeze
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : shared memory command
// Optional build macro ARB_FAIR_EN: when defined, a last_grant flag makes a
// simultaneous request pair alternate between data and fetch; otherwise data
// always wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [AW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic [AW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    arb_state_e    state_q,    state_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic          we_q,       we_d;
    logic [AW-1:0] wdata_q,    wdata_d;
    logic [AW-1:0] if_rdata_q, if_rdata_d;
    logic [AW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
`ifdef ARB_FAIR_EN
    grant_e        last_grant_q, last_grant_d;
`endif

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic pick_data;

    lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Data wins a tie unless fairness is built in and data had the last grant.
`ifdef ARB_FAIR_EN
    assign pick_data = dm_req & ~(if_req & (last_grant_q == GRANT_D));
`else
    assign pick_data = dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef ARB_FAIR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d  = BUSY_D;
                    addr_d   = dm_addr;
                    we_d     = dm_we;
                    wdata_d  = dm_wdata;
                    cnt_load = 1'b1;
`ifdef ARB_FAIR_EN
                    last_grant_d = GRANT_D;
`endif
                end else if (if_req) begin
                    state_d  = BUSY_I;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    cnt_load = 1'b1;
`ifdef ARB_FAIR_EN
                    last_grant_d = GRANT_I;
`endif
                end
            end

            BUSY_I: begin
                if (cnt_zero) begin
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            BUSY_D: begin
                if (cnt_zero) begin
                    // A store completes like a load but leaves dm_rdata alone.
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
`ifdef ARB_FAIR_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
`ifdef ARB_FAIR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // mem_en is decoded from the state register so it is high for exactly
    // the MEM_LAT busy cycles and drops the instant reset is asserted.
    assign mem_en    = (state_q != IDLE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ready = if_ready_q;
    assign dm_ready = dm_ready_q;

    assign stall = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance plus a
// MEM_LAT=1 instance for back-to-back fetch timing). Honours ARB_FAIR_EN.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int L  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main DUT (MEM_LAT = 2) ----------------
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, dm_wdata;
    logic [AW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic          if_ready, dm_ready, stall, mem_en, mem_we;

    mem_port_arbiter #(.MEM_LAT(L), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- second DUT (MEM_LAT = 1) ----------------
    logic          if_req_b, dm_req_b, dm_we_b;
    logic [AW-1:0] if_addr_b, dm_addr_b, dm_wdata_b;
    logic [AW-1:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic          if_ready_b, dm_ready_b, stall_b, mem_en_b, mem_we_b;

    mem_port_arbiter #(.MEM_LAT(1), .AW(AW)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .dm_rdata(dm_rdata_b), .dm_ready(dm_ready_b), .stall(stall_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );
    assign mem_rdata_b = mem_addr_b ^ 32'h5A5A_0000;

    // Initial memory image; word 1 (address 0x4) holds 0x8C010000.
    function automatic logic [31:0] pat(input int i);
        return 32'h8C00_FF00 + 32'(i) * 32'h100;
    endfunction

    // ---------------- memory model for the main DUT ----------------
    // Read data is only valid in the final latency cycle of an access.
    bit [31:0]  phys [256];
    bit [255:0] phys_wr;
    int         en_cnt = 0;

    always @(posedge clk) begin
        en_cnt <= mem_en ? en_cnt + 1 : 0;
        if (mem_en && mem_we && en_cnt == L - 1) begin
            phys[mem_addr[9:2]]    <= mem_wdata;
            phys_wr[mem_addr[9:2]] <= 1'b1;
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (mem_en && en_cnt == L - 1) begin
            mem_rdata = phys_wr[mem_addr[9:2]] ? phys[mem_addr[9:2]] : pat(int'(mem_addr[9:2]));
        end
    end

    // ---------------- transaction-level reference model ----------------
    // An access granted at edge g finishes at edge g+L; the arbiter is free
    // again only after that completion edge.
    int            edge_n;
    int            m_done;
    logic          m_act, m_port_d, m_we, m_if_ready, m_dm_ready;
    logic [31:0]   m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [31:0]   mm [256];
`ifdef ARB_FAIR_EN
    logic          m_last_d;
`endif

    initial begin
        edge_n = 0; m_done = 0; m_act = 0; m_port_d = 0; m_we = 0;
        m_if_ready = 0; m_dm_ready = 0; m_addr = 0; m_wdata = 0;
        m_if_rdata = 0; m_dm_rdata = 0;
`ifdef ARB_FAIR_EN
        m_last_d = 0;
`endif
        for (int i = 0; i < 256; i++) mm[i] = pat(i);
        forever begin
            logic pick_d;
            @(posedge clk);
            edge_n++;
            m_if_ready = 0;
            m_dm_ready = 0;
            if (reset) begin
                m_act = 0; m_we = 0; m_addr = 0; m_wdata = 0;
                m_if_rdata = 0; m_dm_rdata = 0;
`ifdef ARB_FAIR_EN
                m_last_d = 0;
`endif
            end else if (m_act) begin
                if (edge_n == m_done) begin
                    m_act = 0;
                    if (m_port_d) begin
                        m_dm_ready = 1;
                        if (m_we) mm[m_addr[9:2]] = m_wdata;
                        else      m_dm_rdata = mm[m_addr[9:2]];
                    end else begin
                        m_if_ready = 1;
                        m_if_rdata = mm[m_addr[9:2]];
                    end
                end
            end else begin
                pick_d = dm_req;
`ifdef ARB_FAIR_EN
                if (dm_req && if_req && m_last_d) pick_d = 0;
`endif
                if (pick_d || if_req) begin
                    m_act    = 1;
                    m_port_d = pick_d;
                    m_addr   = pick_d ? dm_addr : if_addr;
                    m_we     = pick_d ? dm_we : 1'b0;
                    m_wdata  = pick_d ? dm_wdata : 32'h0;
                    m_done   = edge_n + L;
`ifdef ARB_FAIR_EN
                    m_last_d = pick_d;
`endif
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of the main DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model_ctrl", {mem_en, mem_we, if_ready, dm_ready, stall},
                  {m_act, m_act & m_we, m_if_ready, m_dm_ready,
                   (if_req & ~m_if_ready) | (dm_req & ~m_dm_ready)});
            if (m_act) check("model_addr", mem_addr, m_addr);
            if (m_act && m_we) check("model_wdata", mem_wdata, m_wdata);
            check("model_if_rdata", if_rdata, m_if_rdata);
            check("model_dm_rdata", dm_rdata, m_dm_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0; if_req_b = 0;
        @(negedge clk);
        reset = 0;
    endtask

    // Edges from now until dm_ready is seen (grant edge counts as 1).
    task automatic wait_dm(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (dm_ready) break;
        end
    endtask

    typedef struct {
        logic        if_r;
        logic        dm_r;
        logic        en;
        logic [31:0] addr;
        logic        if_rdy;
        logic        dm_rdy;
        logic        stl;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc;
        int grants;
        logic prev_en;
        logic [3:0] order;

        // Simultaneous fetch/data requests: data granted first.
        tbl[0] = '{1, 1, 1, 32'h10, 0, 0, 1};
        tbl[1] = '{1, 1, 1, 32'h10, 0, 0, 1};
        tbl[2] = '{1, 1, 0, 32'h0,  0, 1, 1};
        tbl[3] = '{1, 0, 1, 32'h4,  0, 0, 1};
        tbl[4] = '{1, 0, 1, 32'h4,  0, 0, 1};
        tbl[5] = '{1, 0, 0, 32'h0,  1, 0, 0};
        tbl[6] = '{0, 0, 0, 32'h0,  0, 0, 0};

        if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        if_req_b = 0; dm_req_b = 0; dm_we_b = 0; if_addr_b = 0; dm_addr_b = 0; dm_wdata_b = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {mem_en, mem_we, if_ready, dm_ready, stall}, 5'b0);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        check("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(negedge clk);
        reset = 0;

        // Single fetch: ready two cycles after grant, stall until then.
        @(negedge clk);
        if_req = 1; if_addr = 32'h4;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (if_ready) break;
            check("fetch_stall", stall, 1'b1);
        end
        check("fetch_latency", cyc, L + 1);
        check("fetch_rdata", if_rdata, 32'h8C01_0000);
        check("fetch_stall_release", stall, 1'b0);
        @(negedge clk);
        if_req = 0;

        // Table: simultaneous requests
        dm_addr = 32'h10; dm_we = 0; if_addr = 32'h4;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if_req = tbl[i].if_r;
            dm_req = tbl[i].dm_r;
            @(posedge clk); #1;
            check("tbl_ctrl", {mem_en, if_ready, dm_ready, stall},
                  {tbl[i].en, tbl[i].if_rdy, tbl[i].dm_rdy, tbl[i].stl});
            if (tbl[i].en) check("tbl_addr", mem_addr, tbl[i].addr);
        end

        // Reset during cycle 1 of a data access
        do_reset();
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h10;
        wait_dm(cyc);
        check("load_latency", cyc, L + 1);
        check("load_rdata", dm_rdata, pat(4));
        @(negedge clk);
        dm_addr = 32'h30;
        @(posedge clk); #1;
        check("abandon_grant", {mem_en, mem_addr}, {1'b1, 32'h30});
        #1 reset = 1;
        #1;
        check("async_rst_ctrl", {mem_en, mem_we, if_ready, dm_ready}, 4'b0);
        check("async_rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        check("async_rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        wait_dm(cyc);
        check("regrant_latency", cyc, L + 1);
        check("regrant_rdata", dm_rdata, pat(12));
        @(negedge clk);
        dm_req = 0;

        // Store
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < L; i++) begin
            @(posedge clk); #1;
            check("store_cmd", {mem_en, mem_we, dm_ready}, 3'b110);
            check("store_addr_wdata", {mem_addr, mem_wdata}, {32'h20, 32'hDEAD_BEEF});
        end
        @(negedge clk);
        dm_req = 0; dm_we = 0;
        @(posedge clk); #1;
        check("store_ready", {dm_ready, mem_en}, 2'b10);
        check("store_rdata_kept", dm_rdata, pat(12));
        @(negedge clk);
        dm_req = 1;
        wait_dm(cyc);
        check("store_readback", dm_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        dm_req = 0;

        // Both requests held: grant order
        do_reset();
        @(negedge clk);
        if_addr = 32'h60; dm_addr = 32'h50; dm_we = 0; if_req = 1; dm_req = 1;
        grants = 0; prev_en = 0; order = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            @(posedge clk); #1;
            if (mem_en && !prev_en) begin
                order[grants] = (mem_addr == 32'h50);
                grants++;
            end
            prev_en = mem_en;
        end
        check("grant_count", grants, 4);
`ifdef ARB_FAIR_EN
        check("grant_order", order, 4'b0101);
`else
        check("grant_order", order, 4'b1111);
`endif

        // MEM_LAT=1 back-to-back fetches
        do_reset();
        @(negedge clk);
        if_req_b = 1; if_addr_b = 32'h100;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("lat1_ctrl", {mem_en_b, if_ready_b, mem_we_b, dm_ready_b, stall_b},
                  {(i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0, (i % 2) == 0});
            if (if_ready_b) check("lat1_rdata", if_rdata_b, 32'h5A5A_0100);
        end
        check("lat1_idle_data", {dm_rdata_b, mem_wdata_b}, 64'h0);
        @(negedge clk);
        if_req_b = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (reset) reset = 0;
            else if ($urandom_range(0, 49) == 0) reset = 1;
            if_req   = ($urandom_range(0, 3) != 0);
            dm_req   = ($urandom_range(0, 2) == 0);
            dm_we    = $urandom_range(0, 1) == 1;
            if_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            dm_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            dm_wdata = $urandom;
        end
        @(negedge clk);
        reset = 0; if_req = 0; dm_req = 0; dm_we = 0;
        repeat (L + 3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
